// File: rtl/parking_pkg.sv
// Shared types and sizes for the parking gate blocks: entry FSM states and code geometry.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } entry_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int CODE_WIDTH = 16;

    function automatic logic is_bcd(input logic [3:0] value);
        return value <= 4'd9;
    endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Counts idle cycles while enabled and flags when the idle limit has been reached.
module inactivity_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Held at zero while disabled so every new entry starts from a clean count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (restart || !enable) begin
            count <= '0;
        end else if (count != CW'(TIMEOUT_CYCLES)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/keypad_code_entry.sv
// Gate keypad front end: collects a 4-digit BCD code per vehicle and reports ack/error/timeout.
module keypad_code_entry
    import parking_pkg::entry_state_t, parking_pkg::IDLE, parking_pkg::COLLECT,
           parking_pkg::READY, parking_pkg::CODE_WIDTH, parking_pkg::is_bcd;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int NUM_DIGITS     = parking_pkg::NUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vehicle_arrival,
    input  logic [3:0]            digit,
    input  logic                  digit_valid,
    input  logic                  enter_key,
    input  logic                  clear_key,
    output logic [CODE_WIDTH-1:0] code,
    output logic                  code_ack,
    output logic [2:0]            digit_count,
    output logic                  entry_error,
    output logic                  entry_timeout
);

    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    entry_state_t state;
    logic         arrival_q;
    logic         any_strobe;
    logic         timer_expired;

    assign any_strobe = digit_valid | enter_key | clear_key;

    inactivity_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (any_strobe || timer_expired),
        .enable  (state != IDLE),
        .expired (timer_expired)
    );

    // arrival_q resets high so a vehicle already waiting through reset must re-arrive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            code          <= '0;
            digit_count   <= '0;
            code_ack      <= 1'b0;
            entry_error   <= 1'b0;
            entry_timeout <= 1'b0;
            arrival_q     <= 1'b1;
        end else begin
            arrival_q     <= vehicle_arrival;
            code_ack      <= 1'b0;
            entry_error   <= 1'b0;
            entry_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (vehicle_arrival && !arrival_q) begin
                        state       <= COLLECT;
                        code        <= '0;
                        digit_count <= '0;
                    end
                end
                COLLECT, READY: begin
                    // Departure beats timeout, which beats clear > enter > digit.
                    if (!vehicle_arrival) begin
                        state       <= IDLE;
                        code        <= '0;
                        digit_count <= '0;
                    end else if (timer_expired) begin
                        state         <= COLLECT;
                        entry_timeout <= 1'b1;
                        code          <= '0;
                        digit_count   <= '0;
                    end else if (clear_key) begin
                        state       <= COLLECT;
                        code        <= '0;
                        digit_count <= '0;
                    end else if (enter_key) begin
                        if (state == READY) begin
                            state    <= IDLE;
                            code_ack <= 1'b1;
                        end else begin
                            entry_error <= 1'b1;
                            code        <= '0;
                            digit_count <= '0;
                        end
                    end else if (digit_valid && state == COLLECT) begin
                        if (!is_bcd(digit)) begin
                            entry_error <= 1'b1;
                        end else begin
                            code        <= {code[CODE_WIDTH-5:0], digit};
                            digit_count <= digit_count + 3'd1;
                            if (digit_count == LAST_DIGIT) begin
                                state <= READY;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/keypad_code_entry.md
KEYPAD_CODE_ENTRY -- requirements
Module: keypad_code_entry

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, idle clock cycles that abort an entry.
REQ-002 SHALL have parameter NUM_DIGITS, default 4, BCD digits per code, fixed at 4 for this release.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port vehicle_arrival  input  1  level; high while a vehicle waits at the gate.
REQ-006 SHALL have port digit  input  4  BCD key value, valid only with digit_valid.
REQ-007 SHALL have port digit_valid  input  1  one-cycle strobe per key press.
REQ-008 SHALL have port enter_key  input  1  one-cycle strobe; submit the code.
REQ-009 SHALL have port clear_key  input  1  one-cycle strobe; discard the digits entered so far.
REQ-010 SHALL have port code  output  16  assembled code; first digit in [15:12], last digit in [3:0].
REQ-011 SHALL have port code_ack  output  1  one-cycle pulse; code is complete and valid.
REQ-012 SHALL have port digit_count  output  3  digits currently held, 0..4.
REQ-013 SHALL have port entry_error  output  1  one-cycle pulse on a short entry or a non-BCD digit.
REQ-014 SHALL have port entry_timeout  output  1  one-cycle pulse when an entry is aborted by inactivity.

Function
REQ-015 SHALL implement the states IDLE, COLLECT and READY.
REQ-016 IDLE: digits and keys ignored; rising vehicle_arrival -> COLLECT with code=0 and digit_count=0.
REQ-017 COLLECT: a valid digit (0..9) shifts into code (code <= {code[11:0],digit}) and increments digit_count, visible the next cycle.
REQ-018 COLLECT: the accept that brings digit_count to 4 SHALL transition to READY.
REQ-019 Digit >9 SHALL be ignored, with entry_error pulsed the next cycle and code/digit_count unchanged.
REQ-020 READY: further digit_valid SHALL be ignored; code stays stable.
REQ-021 READY with enter_key SHALL pulse code_ack the next cycle for exactly one cycle; code holds its value during and after the pulse until the next entry starts; state -> IDLE.
REQ-022 enter_key in COLLECT (digit_count<4) SHALL pulse entry_error, clear code and digit_count, and remain in COLLECT.
REQ-023 clear_key in COLLECT or READY SHALL zero code and digit_count and go to COLLECT; no error pulse.
REQ-024 Simultaneous strobes priority: clear_key > enter_key > digit_valid; lower-priority strobes in that cycle are dropped.
REQ-025 Inactivity counter SHALL reset on any strobe and on entry to COLLECT, and count otherwise in COLLECT/READY.
REQ-026 When the inactivity count reaches TIMEOUT_CYCLES, SHALL pulse entry_timeout, zero code and digit_count, and go to COLLECT.
REQ-027 vehicle_arrival falling in COLLECT/READY SHALL go to IDLE next cycle with code/digit_count cleared, overriding any same-cycle strobe; no ack.
REQ-028 code_ack and entry_error SHALL never assert in the same cycle.

Reset
REQ-029 Asserting rst SHALL immediately force IDLE, code=16'h0000, digit_count=0, code_ack=0, entry_error=0, entry_timeout=0, inactivity counter=0, including mid-entry.
REQ-030 After rst deasserts, SHALL require a fresh rising vehicle_arrival edge to enter COLLECT, even if vehicle_arrival was already high.

Structure
REQ-031 State enum, NUM_DIGITS and the 16-bit code width SHALL live in shared package parking_pkg, which parkingController also uses.
REQ-032 Inactivity counting SHALL be the sub-module inactivity_timer (inputs clk, rst, restart, enable; output expired).

Verification
REQ-033 Arrival, digits 5,9,9,0 one per 3 cycles, then enter -> code=16'h5990, code_ack high for one cycle, the cycle after enter.
REQ-034 Arrival, digits 1,2 then enter -> entry_error one pulse, code=0, digit_count=0, no code_ack.
REQ-035 Digits 3,4,5,6,7 -> code=16'h3456, digit_count=4, 7 ignored; clear_key and digit_valid in the same cycle -> code=0, digit_count=0.
REQ-036 Arrival, digit 8, no key for TIMEOUT_CYCLES -> entry_timeout one pulse, digit_count=0; digit 0xA -> entry_error, code unchanged.
REQ-037 rst low after 2 digits -> all outputs zero immediately; vehicle_arrival drop in READY -> IDLE, no code_ack.
